util_cdc_tx: RTL



---
 rtl/util_cdc_pkg.sv | 23 ++
 rtl/util_sync.sv | 39 +++
 rtl/util_cdc_tx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/util_cdc_pkg.sv
// ---------------------------------------------------------------------------
// util_cdc_pkg
// Shared definitions for the toggle-handshake clock-domain crossing.
// The transmit side (util_cdc_tx) and the receive side both import this
// package, so the state encoding and defaults stay the same at both ends.
//
// Contents:
//   cdc_state_e                  handshake FSM state encoding
//   CDC_TIMEOUT_CYCLES_DEFAULT   default acknowledge-timeout length
//   CDC_SYNC_STAGES              depth of the toggle synchronizers
// ---------------------------------------------------------------------------
package util_cdc_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        IDLE     = 2'd1,
        WAIT_ACK = 2'd2
    } cdc_state_e;

    localparam int unsigned CDC_TIMEOUT_CYCLES_DEFAULT = 1024;
    localparam int unsigned CDC_SYNC_STAGES            = 2;

endpackage : util_cdc_pkg

// File: rtl/util_sync.sv
// ---------------------------------------------------------------------------
// util_sync
// Two-flop synchronizer for signals that are asynchronous to clk_i.
// It is kept as a separate module so the ASYNC_REG attributes on its
// flops can be found and applied by the implementation tools.
//
// Ports:
//   clk_i      in   1      destination-domain clock
//   reset_n_i  in   1      asynchronous active-low reset
//   d          in   WIDTH  asynchronous input
//   q          out  WIDTH  synchronized output (two clk_i edges of latency)
// ---------------------------------------------------------------------------
module util_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta_q;
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make sync_q take the pre-edge
            // meta_q, giving a real two-stage pipeline instead of one flop.
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule : util_sync

// File: rtl/util_cdc_tx.sv
// ---------------------------------------------------------------------------
// util_cdc_tx
// Transmit end of a toggle-handshake clock-domain crossing for multi-bit
// words. A word accepted on valid/ready is held on cdc_data_o while
// cdc_req_o toggles; the far end returns a toggled acknowledge, which is
// synchronized back here before the block reopens. One word in flight.
//
// Optional feature (macro UTIL_CDC_TX_TIMEOUT_EN):
//   defined   - a saturating counter times the WAIT_ACK state; timeout_o
//               sets sticky after TIMEOUT_CYCLES waiting cycles, or when an
//               acknowledge toggle arrives while IDLE.
//   undefined - no counter, timeout_o tied low.
//
// Ports:
//   clk_i       in   1      source-domain clock
//   reset_n_i   in   1      asynchronous active-low reset
//   valid_i     in   1      upstream word valid
//   ready_o     out  1      block can accept a word (state == IDLE)
//   data_i      in   WIDTH  upstream word
//   cdc_req_o   out  1      request toggle to far domain (registered)
//   cdc_data_o  out  WIDTH  held word to far domain (registered); needs a
//                           max-delay constraint of one far-domain period
//   cdc_ack_i   in   1      acknowledge toggle from far domain (async)
//   timeout_o   out  1      sticky acknowledge-timeout flag
// ---------------------------------------------------------------------------
module util_cdc_tx
    import util_cdc_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = CDC_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             cdc_req_o,
    output logic [WIDTH-1:0] cdc_data_o,
    input  logic             cdc_ack_i,
    output logic             timeout_o
);

    // The synchronizer resets to 0, which is not a real sample of the far
    // end. INIT waits this many edges so the comparison uses flushed data.
    localparam int FLUSH_W = $clog2(CDC_SYNC_STAGES + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(CDC_SYNC_STAGES);

    cdc_state_e         state_q;
    logic               req_q;
    logic [WIDTH-1:0]   data_q;
    logic [FLUSH_W-1:0] flush_q;
    logic               ack_s;
    logic               ack_match;

    util_sync #(
        .WIDTH (1)
    ) u_ack_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .d         (cdc_ack_i),
        .q         (ack_s)
    );

    // Far end has caught up with the last request toggle.
    assign ack_match = (ack_s == req_q);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= INIT;
            req_q   <= 1'b0;
            data_q  <= '0;
            flush_q <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    // A far end that was not reset may still report an
                    // old toggle; stay here until it agrees with req_q.
                    if (flush_q != FLUSH_DONE) begin
                        flush_q <= flush_q + 1'b1;
                    end else if (ack_match) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    // An ack toggle seen here is a protocol violation and
                    // is deliberately ignored by the handshake.
                    if (valid_i) begin
                        data_q  <= data_i;
                        req_q   <= ~req_q;
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_match) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign ready_o    = (state_q == IDLE);
    assign cdc_req_o  = req_q;
    assign cdc_data_o = data_q;

`ifdef UTIL_CDC_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && valid_i) begin
                wait_cnt_q <= '0;
            end else if (state_q == WAIT_ACK && wait_cnt_q != CNT_MAX) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end

            // Sets on the edge where the count reaches TIMEOUT_CYCLES, or
            // on a stray ack toggle while IDLE. Cleared only by reset.
            if ((state_q == WAIT_ACK && wait_cnt_q == CNT_LAST) ||
                (state_q == IDLE && !ack_match)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule : util_cdc_tx
